// File: rtl/gen_addr_mc.sv
`default_nettype none
// =============================================================================
// Module   : gen_addr_mc
// Purpose  : Feeds the gen->lock FIFO from round-robin link FIFOs, an external
//            update FIFO, or self-generated update keys when links are idle.
// Revision : 1.0 - initial multi-channel release
// =============================================================================
module gen_addr_mc #(
  parameter int KEY_WIDTH   = 32,
  parameter int MSG_WIDTH   = 32,
  parameter int NUM_LINK_CH = 2,
  parameter int PROC_ID     = 0,
  parameter int UPDATE_MODE = 0,
  parameter int ACCUM_MODE  = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_LINK_CH*(KEY_WIDTH+MSG_WIDTH)-1:0] link_q,
  input  logic [NUM_LINK_CH-1:0]                      link_empty,
  output logic [NUM_LINK_CH-1:0]                      link_rdreq,
  input  logic [KEY_WIDTH+MSG_WIDTH-1:0]              ext_q,
  input  logic                                        ext_empty,
  output logic                                        ext_rdreq,
  output logic [KEY_WIDTH+MSG_WIDTH:0]                out_data,
  input  logic                                        out_full,
  output logic                                        out_wrreq,
  input  logic                                        compute_almost_full,
  input  logic                                        start_update,
  input  logic                                        process_ext_updates,
  input  logic [31:0]                                 num_keys,
  input  logic [3:0]                                  max_fpga_procs,
  input  logic [4:0]                                  log_2_num_workers_in,
  input  logic [31:0]                                 shard_id,
  output logic                                        start_key_selection,
  output logic [15:0]                                 pass_cnt,
  output logic                                        busy
);

  localparam int C_E_WIDTH = KEY_WIDTH + MSG_WIDTH;
  localparam int C_CH_W    = (NUM_LINK_CH > 1) ? $clog2(NUM_LINK_CH) : 1;
  localparam logic [C_CH_W-1:0] C_LAST_CH = C_CH_W'(NUM_LINK_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WRITE   = 2'd2,
    GEN_KEY = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_src_ext;
  logic [C_CH_W-1:0]      r_src_ch;
  logic [C_CH_W-1:0]      r_rr_ptr;
  logic [31:0]            r_key_cnt;
  logic [15:0]            r_pass_cnt;
  logic [C_E_WIDTH-1:0]   r_hold;
  logic                   r_held;
  logic [NUM_LINK_CH-1:0] r_link_rdreq;
  logic                   r_ext_rdreq;
  logic [C_E_WIDTH:0]     r_out_data;
  logic                   r_out_wrreq;
  logic                   r_start_key_sel;

  logic                   w_grant_valid;
  logic [C_CH_W-1:0]      w_grant_ch;
  int                     w_off;
  int                     w_best;
  logic [C_E_WIDTH-1:0]   w_link_sel;
  logic [C_E_WIDTH-1:0]   w_src_q;
  logic [C_E_WIDTH-1:0]   w_wr_data;
  logic [31:0]            w_stride;
  logic [31:0]            w_key_full;
  logic [KEY_WIDTH-1:0]   w_gen_key;
  logic                   w_rollover;

  // Pick the non-empty channel with the smallest cyclic distance from r_rr_ptr.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_ch    = '0;
    w_best        = NUM_LINK_CH;
    w_off         = 0;
    for (int i = 0; i < NUM_LINK_CH; i++) begin
      w_off = (i + NUM_LINK_CH - int'(r_rr_ptr)) % NUM_LINK_CH;
      if (!link_empty[i] && (w_off < w_best)) begin
        w_best        = w_off;
        w_grant_valid = 1'b1;
        w_grant_ch    = C_CH_W'(i);
      end
    end
  end

  always_comb begin
    w_link_sel = '0;
    for (int i = 0; i < NUM_LINK_CH; i++) begin
      if (r_src_ch == C_CH_W'(i)) begin
        w_link_sel = link_q[i*C_E_WIDTH +: C_E_WIDTH];
      end
    end
  end

  assign w_src_q   = r_src_ext ? ext_q : w_link_sel;
  // Once captured, the held copy wins so a stalled write never depends on q again.
  assign w_wr_data = r_held ? r_hold : w_src_q;

  assign w_stride   = {28'd0, max_fpga_procs};
  assign w_key_full = (r_key_cnt << log_2_num_workers_in) + shard_id;
  assign w_rollover = (num_keys <= w_stride) || (r_key_cnt >= (num_keys - w_stride));

  if (KEY_WIDTH <= 32) begin : g_key_trunc
    assign w_gen_key = w_key_full[KEY_WIDTH-1:0];
  end else begin : g_key_ext
    assign w_gen_key = {{(KEY_WIDTH-32){1'b0}}, w_key_full};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_src_ext       <= 1'b0;
      r_src_ch        <= '0;
      r_rr_ptr        <= '0;
      r_key_cnt       <= 32'(PROC_ID);
      r_pass_cnt      <= '0;
      r_hold          <= '0;
      r_held          <= 1'b0;
      r_link_rdreq    <= '0;
      r_ext_rdreq     <= 1'b0;
      r_out_data      <= '0;
      r_out_wrreq     <= 1'b0;
      r_start_key_sel <= 1'b0;
    end else begin
      r_link_rdreq    <= '0;
      r_ext_rdreq     <= 1'b0;
      r_out_wrreq     <= 1'b0;
      r_start_key_sel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (process_ext_updates) begin
            if (!ext_empty) begin
              r_ext_rdreq <= 1'b1;
              r_src_ext   <= 1'b1;
              r_state     <= WAIT_RD;
            end
          end else if (start_update) begin
            if (w_grant_valid) begin
              r_link_rdreq <= NUM_LINK_CH'(1) << w_grant_ch;
              r_src_ext    <= 1'b0;
              r_src_ch     <= w_grant_ch;
              r_rr_ptr     <= (w_grant_ch == C_LAST_CH) ? '0 : w_grant_ch + 1'b1;
              r_state      <= WAIT_RD;
            end else if (!compute_almost_full) begin
              r_state <= GEN_KEY;
            end
          end
        end
        WAIT_RD: r_state <= WRITE;
        WRITE: begin
          if (!r_held) begin
            r_hold <= w_src_q;
            r_held <= 1'b1;
          end
          if (!out_full) begin
            r_out_data  <= {1'(ACCUM_MODE), w_wr_data};
            r_out_wrreq <= 1'b1;
            r_held      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        GEN_KEY: begin
          if (!out_full) begin
            r_out_data  <= {1'(UPDATE_MODE), w_gen_key, {MSG_WIDTH{1'b0}}};
            r_out_wrreq <= 1'b1;
            if (w_rollover) begin
              r_key_cnt       <= 32'(PROC_ID);
              r_start_key_sel <= 1'b1;
              r_pass_cnt      <= r_pass_cnt + 16'd1;
            end else begin
              r_key_cnt <= r_key_cnt + w_stride;
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign link_rdreq          = r_link_rdreq;
  assign ext_rdreq           = r_ext_rdreq;
  assign out_data            = r_out_data;
  assign out_wrreq           = r_out_wrreq;
  assign start_key_selection = r_start_key_sel;
  assign pass_cnt            = r_pass_cnt;
  assign busy                = (r_state != IDLE);

endmodule
`default_nettype wire
